hazard_ctrl_n: RTL and testbench
================================

# hazard_ctrl_n

Parametrised hazard controller for the in-order RISC-V pipeline with NUM_MEM stages between Execute and Writeback. Generalises data forwarding and load-use stalling to any memory-pipeline depth, and adds a stall sequencer for a multi-cycle MUL/DIV unit in Execute. Sits beside the datapath and drives every stall, flush and forward-select line from Fetch to Memory.

## Interface
- NUM_MEM, default 2: number of memory stages M1..M[NUM_MEM]; legal range 1..6.
- MD_LAT, default 8: MUL/DIV occupancy in cycles; must be 1..255.
- FW_W, default $clog2(NUM_MEM+2): width of a forward select.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset, sampled on the clk rising edge.
- Rs1_D, Rs2_D  input  5  Decode source registers.
- Rs1_E, Rs2_E, Rd_E  input  5  Execute sources and destination.
- Load_E  input  1  Execute instruction is a load (ResultSrc bit 0).
- MulDiv_E  input  1  Execute instruction uses the multi-cycle unit.
- Rd_M  input  5*NUM_MEM  destinations; slice k (bits 5k+4:5k) belongs to M[k+1].
- RegWrite_M, Load_M  input  NUM_MEM  per-stage write enable and load flag; bit k is M[k+1].
- Rd_W  input  5; RegWrite_W  input  1  Writeback destination and enable.
- PC_Src_E  input  2  non-zero means a redirect in Execute.
- Stall_F, Stall_D, Stall_E  output  1  hold the PC / IF-ID / ID-EX registers.
- Flush_D, Flush_E, Flush_M  output  1  bubble into ID-EX input side: ID, EX and M1.
- ForwardA_E, ForwardB_E  output  FW_W  operand select: 0 regfile, 1 W, k+2 M[k+1].
- MD_Busy  output  1  sequencer is in BUSY; MD_Done  output  1  one-cycle completion pulse.

## Operation
- Forwarding, per operand, combinational. If Rs == 0, select 0. Otherwise the youngest match wins: M1 first, then M2..M[NUM_MEM], then W; a stage matches when its Rd == Rs and its RegWrite is set.
- Load-use hazard (lu). Asserted when Rs1_D or Rs2_D equals a non-zero Rd of a load in E (Load_E) or in M1..M[NUM_MEM-1] (Load_M). Load data is forwardable only from M[NUM_MEM] onward. With NUM_MEM = 1, only E is checked.
- Redirect (br) = |PC_Src_E.
- MUL/DIV sequencer states: IDLE, BUSY, DONE.
  - IDLE to BUSY when MulDiv_E && !br; the counter loads MD_LAT-1.
  - BUSY decrements each cycle. At 0 it moves to DONE.
  - DONE moves to IDLE unconditionally. MulDiv_E is ignored in DONE because the same instruction is still in E.
  - md_stall = (IDLE && MulDiv_E) || BUSY.
- Outputs:
  - Stall_F = Stall_D = lu || md_stall.
  - Stall_E = md_stall; Flush_M = md_stall.
  - Flush_D = br && !md_stall.
  - Flush_E = (lu || br) && !md_stall. While E is held, ID-EX must not be flushed.
  - MD_Busy = (state == BUSY); MD_Done = (state == DONE).
- Priority: md_stall dominates lu and br. A load-use hazard present during BUSY persists and is re-evaluated after DONE.
- Reset (reset == 0 at an edge) forces IDLE with counter 0. This holds mid-BUSY: the next cycle shows MD_Busy = 0, and stalls are driven only by the combinational terms.

## Timing
- Forward, lu and br outputs are combinational in the same cycle. Only the sequencer is registered.
- MUL/DIV in E at cycle t: E is held for cycles t..t+MD_LAT-1. MD_Done and E release happen at t+MD_LAT, so total E occupancy is MD_LAT+1 cycles.
- Counter width is 8 bits; it never wraps because it loads MD_LAT-1 ≤ 254.
- Back-to-back MUL/DIV: the second instruction enters E at t+MD_LAT+1 with the sequencer in IDLE and starts immediately.
- Outputs after reset: MD_Busy = 0 and MD_Done = 0. All other outputs follow their inputs with the sequencer in IDLE.

## Structure
- The shared pipeline package holds:
  - localparams for the forward-select encodings (FW_RF = 0, FW_W = 1, FW_M_BASE = 2);
  - the sequencer state enum (2 bits);
  - REG_ADDR_W = 5.
- One sub-module, hazard_fwd_sel, instantiated per operand: a priority search over the flattened M-stage vectors plus W, implemented as a generate loop. The sequencer and stall logic stay in the top module.

## Test plan
- NUM_MEM = 3: Rs1_E = 7; Rd_M slices M1 = 7, M3 = 7, all RegWrite set → ForwardA_E = 2. Drop RegWrite_M[0] → 4. Then Rs1_E = 0 → 0.
- NUM_MEM = 3, load in M2 with Rd = 9 and Rs2_D = 9 → Stall_F = Stall_D = Flush_E = 1. Same load in M3 → no stall, and ForwardB_E = 4 on the next cycle.
- MD_LAT = 4, MulDiv_E high from cycle 10:
  - cycles 10–13: Stall_E = Flush_M = 1;
  - cycle 11: MD_Busy rises;
  - cycle 14: MD_Done = 1 and Stall_E = 0;
  - cycle 15: IDLE.
- Load-use in D during BUSY, with PC_Src_E = 2 in the same cycle as a non-MulDiv hazard → Flush_D = Flush_E = 1 only when the sequencer is IDLE. During BUSY, Flush_E stays 0.
- Reset pulsed low at the second BUSY cycle → next cycle MD_Busy = 0 and Stall_E = 0 (MulDiv_E low), and no MD_Done pulse.

Source files
------------

// File: rtl/hazard_ctrl_n_pkg.sv
// Shared pipeline definitions for the hazard controller: address width,
// forward-select encodings, sequencer states and small compare helpers.
package hazard_ctrl_n_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned MD_CNT_W   = 8;

  localparam int unsigned FW_RF      = 0;
  localparam int unsigned FW_W       = 1;
  localparam int unsigned FW_M_BASE  = 2;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // A producing stage matches a source when it writes the same register.
  function automatic logic reg_hit(input logic [REG_ADDR_W-1:0] rs,
                                   input logic [REG_ADDR_W-1:0] rd,
                                   input logic                  we);
    return we && (rd == rs);
  endfunction

  // A non-zero destination read by either Decode source.
  function automatic logic src_hit(input logic [REG_ADDR_W-1:0] rd,
                                   input logic [REG_ADDR_W-1:0] rs1,
                                   input logic [REG_ADDR_W-1:0] rs2);
    return (rd != '0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/hazard_ctrl_n_if.sv
// Datapath <-> hazard controller bundle: pipeline register fields in,
// stall / flush / forward-select lines out.
interface hazard_ctrl_n_if #(
  parameter int unsigned NUM_MEM = 2,
  parameter int unsigned FW_W    = $clog2(NUM_MEM + 2)
);

  localparam int unsigned AW = hazard_ctrl_n_pkg::REG_ADDR_W;

  logic [AW-1:0]         Rs1_D;
  logic [AW-1:0]         Rs2_D;
  logic [AW-1:0]         Rs1_E;
  logic [AW-1:0]         Rs2_E;
  logic [AW-1:0]         Rd_E;
  logic                  Load_E;
  logic                  MulDiv_E;
  logic [AW*NUM_MEM-1:0] Rd_M;
  logic [NUM_MEM-1:0]    RegWrite_M;
  logic [NUM_MEM-1:0]    Load_M;
  logic [AW-1:0]         Rd_W;
  logic                  RegWrite_W;
  logic [1:0]            PC_Src_E;

  logic                  Stall_F;
  logic                  Stall_D;
  logic                  Stall_E;
  logic                  Flush_D;
  logic                  Flush_E;
  logic                  Flush_M;
  logic [FW_W-1:0]       ForwardA_E;
  logic [FW_W-1:0]       ForwardB_E;
  logic                  MD_Busy;
  logic                  MD_Done;

  modport master (
    output Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Load_E, MulDiv_E,
           Rd_M, RegWrite_M, Load_M, Rd_W, RegWrite_W, PC_Src_E,
    input  Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Flush_M,
           ForwardA_E, ForwardB_E, MD_Busy, MD_Done
  );

  modport slave (
    input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Load_E, MulDiv_E,
           Rd_M, RegWrite_M, Load_M, Rd_W, RegWrite_W, PC_Src_E,
    output Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Flush_M,
           ForwardA_E, ForwardB_E, MD_Busy, MD_Done
  );

endinterface

// File: rtl/hazard_fwd_sel.sv
// Forward-select for one Execute operand: youngest producing stage wins,
// M1 first through M[NUM_MEM], then Writeback, else the register file.
module hazard_fwd_sel
  import hazard_ctrl_n_pkg::*;
#(
  parameter int unsigned NUM_MEM = 2,
  parameter int unsigned SEL_W   = 2
) (
  input  logic [REG_ADDR_W-1:0]         rs,
  input  logic [REG_ADDR_W*NUM_MEM-1:0] rd_m,
  input  logic [NUM_MEM-1:0]            reg_write_m,
  input  logic [REG_ADDR_W-1:0]         rd_w,
  input  logic                          reg_write_w,
  output logic [SEL_W-1:0]              sel_c
);

  logic [NUM_MEM-1:0] hit;

  for (genvar k = 0; k < NUM_MEM; k++) begin : g_stage
    assign hit[k] = reg_hit(rs, rd_m[REG_ADDR_W*k +: REG_ADDR_W], reg_write_m[k]);
  end

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    sel_c = reg_hit(rs, rd_w, reg_write_w) ? SEL_W'(FW_W) : SEL_W'(FW_RF);
    for (int k = int'(NUM_MEM) - 1; k >= 0; k--) begin
      if (hit[k]) sel_c = SEL_W'(FW_M_BASE + 32'(k));
    end
    if (rs == '0) sel_c = SEL_W'(FW_RF);
  end

endmodule

// File: rtl/hazard_ctrl_n.sv
// Pipeline hazard controller: operand forwarding, load-use stalls, redirect
// flushes and the multi-cycle MUL/DIV stall sequencer.
module hazard_ctrl_n #(
  parameter int unsigned NUM_MEM = 2,
  parameter int unsigned MD_LAT  = 8,
  parameter int unsigned FW_W    = $clog2(NUM_MEM + 2)
) (
  input logic         clk,
  input logic         reset,
  hazard_ctrl_n_if.slave hz
);

  import hazard_ctrl_n_pkg::*;

  localparam int unsigned AW = REG_ADDR_W;

  md_state_e             state;
  logic [MD_CNT_W-1:0]   cnt;
  logic                  busy;
  logic                  done;

  logic                  lu_e_c;
  logic [NUM_MEM-1:0]    lu_m_c;
  logic                  lu_c;
  logic                  br_c;
  logic                  md_stall_c;
  logic                  unused_load_last;

  // The last M stage delivers load data, so it never causes a load-use stall.
  assign unused_load_last = hz.Load_M[NUM_MEM-1];

  assign lu_e_c = hz.Load_E && src_hit(hz.Rd_E, hz.Rs1_D, hz.Rs2_D);

  always_comb begin
    lu_m_c = '0;
    for (int k = 0; k < int'(NUM_MEM) - 1; k++) begin
      lu_m_c[k] = hz.Load_M[k] && src_hit(hz.Rd_M[AW*k +: AW], hz.Rs1_D, hz.Rs2_D);
    end
  end

  assign lu_c       = lu_e_c || (|lu_m_c);
  assign br_c       = |hz.PC_Src_E;
  assign md_stall_c = ((state == MD_IDLE) && hz.MulDiv_E) || (state == MD_BUSY);

  // MUL/DIV sequencer; the first occupancy cycle is spent in IDLE, so BUSY
  // covers the remaining MD_LAT-1 cycles and leaves as the counter reaches 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (hz.MulDiv_E && !br_c) begin
            if (MD_LAT <= 1) begin
              state <= MD_DONE;
              done  <= 1'b1;
            end else begin
              state <= MD_BUSY;
              cnt   <= MD_CNT_W'(MD_LAT - 1);
              busy  <= 1'b1;
            end
          end
        end
        MD_BUSY: begin
          if (cnt <= MD_CNT_W'(1)) begin
            state <= MD_DONE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - MD_CNT_W'(1);
          end
        end
        MD_DONE: begin
          state <= MD_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= MD_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign hz.Stall_F = lu_c || md_stall_c;
  assign hz.Stall_D = lu_c || md_stall_c;
  assign hz.Stall_E = md_stall_c;
  assign hz.Flush_M = md_stall_c;
  assign hz.Flush_D = br_c && !md_stall_c;
  assign hz.Flush_E = (lu_c || br_c) && !md_stall_c;
  assign hz.MD_Busy = busy;
  assign hz.MD_Done = done;

  hazard_fwd_sel #(
    .NUM_MEM (NUM_MEM),
    .SEL_W   (FW_W)
  ) u_fwd_a (
    .rs          (hz.Rs1_E),
    .rd_m        (hz.Rd_M),
    .reg_write_m (hz.RegWrite_M),
    .rd_w        (hz.Rd_W),
    .reg_write_w (hz.RegWrite_W),
    .sel_c       (hz.ForwardA_E)
  );

  hazard_fwd_sel #(
    .NUM_MEM (NUM_MEM),
    .SEL_W   (FW_W)
  ) u_fwd_b (
    .rs          (hz.Rs2_E),
    .rd_m        (hz.Rd_M),
    .reg_write_m (hz.RegWrite_M),
    .rd_w        (hz.Rd_W),
    .reg_write_w (hz.RegWrite_W),
    .sel_c       (hz.ForwardB_E)
  );

endmodule

// File: tb/tb_hazard_ctrl_n.sv
// Scoreboard bench for hazard_ctrl_n with NUM_MEM = 3 and MD_LAT = 4.
module tb_hazard_ctrl_n;

  localparam int unsigned NM  = 3;
  localparam int unsigned LAT = 4;
  localparam int unsigned SW  = 3;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  hazard_ctrl_n_if #(.NUM_MEM(NM), .FW_W(SW)) hz ();

  hazard_ctrl_n #(
    .NUM_MEM (NM),
    .MD_LAT  (LAT),
    .FW_W    (SW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  typedef struct {
    logic          sf, sd, se, fd, fe, fm;
    logic [SW-1:0] fa, fb;
    logic          busy, done;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  // Cycles since a MUL/DIV started; -1 when the sequencer is idle.
  int   age = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [SW-1:0] ref_fwd(input logic [4:0] rs);
    if (rs == 5'd0) return '0;
    for (int k = 0; k < int'(NM); k++)
      if (hz.RegWrite_M[k] && hz.Rd_M[5*k +: 5] == rs) return SW'(k + 2);
    if (hz.RegWrite_W && hz.Rd_W == rs) return SW'(1);
    return '0;
  endfunction

  function automatic logic ref_lu();
    logic [4:0] rd;
    if (hz.Load_E && hz.Rd_E != 5'd0 && (hz.Rd_E == hz.Rs1_D || hz.Rd_E == hz.Rs2_D)) return 1'b1;
    for (int k = 0; k < int'(NM) - 1; k++) begin
      rd = hz.Rd_M[5*k +: 5];
      if (hz.Load_M[k] && rd != 5'd0 && (rd == hz.Rs1_D || rd == hz.Rs2_D)) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic push_expect();
    exp_t e;
    logic lu, br, mds;
    lu     = ref_lu();
    br     = (hz.PC_Src_E != 2'd0);
    e.busy = (age >= 1) && (age <= int'(LAT) - 1);
    e.done = (age == int'(LAT));
    mds    = ((age < 0) && hz.MulDiv_E) || e.busy;
    e.sf   = lu || mds;
    e.sd   = lu || mds;
    e.se   = mds;
    e.fm   = mds;
    e.fd   = br && !mds;
    e.fe   = (lu || br) && !mds;
    e.fa   = ref_fwd(hz.Rs1_E);
    e.fb   = ref_fwd(hz.Rs2_E);
    sb.push_back(e);
  endtask

  task automatic pop_compare();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    check("Stall_F",    32'(hz.Stall_F),    32'(e.sf));
    check("Stall_D",    32'(hz.Stall_D),    32'(e.sd));
    check("Stall_E",    32'(hz.Stall_E),    32'(e.se));
    check("Flush_D",    32'(hz.Flush_D),    32'(e.fd));
    check("Flush_E",    32'(hz.Flush_E),    32'(e.fe));
    check("Flush_M",    32'(hz.Flush_M),    32'(e.fm));
    check("ForwardA_E", 32'(hz.ForwardA_E), 32'(e.fa));
    check("ForwardB_E", 32'(hz.ForwardB_E), 32'(e.fb));
    check("MD_Busy",    32'(hz.MD_Busy),    32'(e.busy));
    check("MD_Done",    32'(hz.MD_Done),    32'(e.done));
  endtask

  // One clock: expectation pushed with stimulus, compared mid-cycle, model
  // advanced on the edge that the DUT sees.
  task automatic step();
    push_expect();
    @(negedge clk);
    pop_compare();
    @(posedge clk);
    if (!reset) age = -1;
    else if (age >= 0) begin
      age++;
      if (age > int'(LAT)) age = -1;
    end else if (hz.MulDiv_E && hz.PC_Src_E == 2'd0) age = 1;
    #1;
  endtask

  task automatic clear_in();
    hz.Rs1_D = '0; hz.Rs2_D = '0; hz.Rs1_E = '0; hz.Rs2_E = '0; hz.Rd_E = '0;
    hz.Load_E = 1'b0; hz.MulDiv_E = 1'b0; hz.Rd_M = '0; hz.RegWrite_M = '0;
    hz.Load_M = '0; hz.Rd_W = '0; hz.RegWrite_W = 1'b0; hz.PC_Src_E = '0;
  endtask

  task automatic set_rd_m(input int k, input logic [4:0] v);
    hz.Rd_M[5*k +: 5] = v;
  endtask

  initial begin
    reset = 1'b0;
    clear_in();
    @(posedge clk);
    #1;
    step();
    step();
    reset = 1'b1;

    // Forwarding priority: M1 over M3, then M3, then x0.
    hz.Rs1_E = 5'd7; set_rd_m(0, 5'd7); set_rd_m(2, 5'd7); hz.RegWrite_M = 3'b111;
    step();
    hz.RegWrite_M = 3'b110;
    step();
    hz.Rs1_E = 5'd0;
    step();
    clear_in();
    hz.Rs2_E = 5'd5; hz.Rd_W = 5'd5; hz.RegWrite_W = 1'b1;
    step();
    set_rd_m(1, 5'd5); hz.RegWrite_M = 3'b010;
    step();

    // Load in M2 stalls; in M3 it forwards instead.
    clear_in();
    set_rd_m(1, 5'd9); hz.Load_M = 3'b010; hz.RegWrite_M = 3'b010; hz.Rs2_D = 5'd9;
    step();
    clear_in();
    set_rd_m(2, 5'd9); hz.Load_M = 3'b100; hz.RegWrite_M = 3'b100; hz.Rs2_D = 5'd9;
    step();
    hz.Rs2_D = 5'd0; hz.Rs2_E = 5'd9;
    step();

    // Load in E, then x0 destination.
    clear_in();
    hz.Load_E = 1'b1; hz.Rd_E = 5'd3; hz.Rs1_D = 5'd3;
    step();
    hz.Rd_E = 5'd0; hz.Rs1_D = 5'd0;
    step();

    // Redirect alone, then with a load-use hazard.
    clear_in();
    hz.PC_Src_E = 2'd2;
    step();
    hz.Load_E = 1'b1; hz.Rd_E = 5'd4; hz.Rs2_D = 5'd4;
    step();

    // MUL/DIV with redirect and load-use arriving during BUSY.
    clear_in();
    hz.MulDiv_E = 1'b1;
    step();
    hz.PC_Src_E = 2'd2; set_rd_m(0, 5'd6); hz.Load_M = 3'b001; hz.Rs1_D = 5'd6;
    repeat (LAT) step();
    hz.MulDiv_E = 1'b0;
    step();
    hz.PC_Src_E = 2'd0;
    step();

    // Back-to-back MUL/DIV.
    clear_in();
    hz.MulDiv_E = 1'b1;
    repeat (2 * (LAT + 1) + 1) step();
    hz.MulDiv_E = 1'b0;
    repeat (LAT + 1) step();

    // MUL/DIV with a same-cycle redirect never starts.
    hz.MulDiv_E = 1'b1; hz.PC_Src_E = 2'd1;
    step();
    hz.MulDiv_E = 1'b0; hz.PC_Src_E = 2'd0;
    step();

    // Reset at the second BUSY cycle.
    hz.MulDiv_E = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1; hz.MulDiv_E = 1'b0;
    repeat (LAT + 1) step();

    // Random traffic over a small register range to provoke matches.
    for (int i = 0; i < 300; i++) begin
      hz.Rs1_D = 5'($urandom_range(0, 3)); hz.Rs2_D = 5'($urandom_range(0, 3));
      hz.Rs1_E = 5'($urandom_range(0, 3)); hz.Rs2_E = 5'($urandom_range(0, 3));
      hz.Rd_E  = 5'($urandom_range(0, 3)); hz.Rd_W  = 5'($urandom_range(0, 3));
      for (int k = 0; k < int'(NM); k++) set_rd_m(k, 5'($urandom_range(0, 3)));
      hz.RegWrite_M = 3'($urandom); hz.Load_M = 3'($urandom);
      hz.Load_E     = 1'($urandom); hz.RegWrite_W = 1'($urandom);
      hz.MulDiv_E   = ($urandom_range(0, 3) == 0);
      hz.PC_Src_E   = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      reset         = ($urandom_range(0, 39) != 0);
      step();
    end
    reset = 1'b1;
    clear_in();
    step();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
